// File: rtl/defines_pkg.sv
// Shared decode constants for the MIPS ID stage: opcodes, functs, ALU encodings.
package defines_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_LW      = 6'h23;

   localparam logic [5:0] FUNCT_SLL = 6'h00;
   localparam logic [5:0] FUNCT_SRL = 6'h02;
   localparam logic [5:0] FUNCT_SRA = 6'h03;
   localparam logic [5:0] FUNCT_AND = 6'h24;
   localparam logic [5:0] FUNCT_OR  = 6'h25;
   localparam logic [5:0] FUNCT_XOR = 6'h26;
   localparam logic [5:0] FUNCT_NOR = 6'h27;

   localparam logic [7:0] EXE_NOP_OP = 8'h00;
   localparam logic [7:0] EXE_AND_OP = 8'h24;
   localparam logic [7:0] EXE_OR_OP  = 8'h25;
   localparam logic [7:0] EXE_XOR_OP = 8'h26;
   localparam logic [7:0] EXE_NOR_OP = 8'h27;
   localparam logic [7:0] EXE_SLL_OP = 8'h7C;
   localparam logic [7:0] EXE_SRL_OP = 8'h02;
   localparam logic [7:0] EXE_SRA_OP = 8'h03;
   localparam logic [7:0] EXE_LW_OP  = 8'hE3;

   localparam logic [2:0] EXE_RES_NOP        = 3'b000;
   localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
   localparam logic [2:0] EXE_RES_SHIFT      = 3'b010;
   localparam logic [2:0] EXE_RES_LOAD_STORE = 3'b111;

   localparam logic [4:0]  NOPRegAddr   = 5'b00000;
   localparam logic        WriteEnable  = 1'b1;
   localparam logic        WriteDisable = 1'b0;
   localparam logic [31:0] ZeroWord     = 32'h0000_0000;

endpackage

// File: rtl/id_stage_if.sv
// Registered ID/EX payload bundle; the ID stage drives it, EX consumes it.
interface id_stage_if
   import defines_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int ALUOP_W    = 8,
   parameter int ALUSEL_W   = 3
);

   logic                  ex_valid_o;
   logic [DATA_W-1:0]     ex_pc_o;
   logic [ALUOP_W-1:0]    ex_aluop_o;
   logic [ALUSEL_W-1:0]   ex_alusel_o;
   logic [DATA_W-1:0]     ex_reg1_o;
   logic [DATA_W-1:0]     ex_reg2_o;
   logic [REG_ADDR_W-1:0] ex_wd_o;
   logic                  ex_wreg_o;
   logic                  ex_is_load_o;
   logic                  ex_inst_invalid_o;

   modport master (
      output ex_valid_o, ex_pc_o, ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o,
             ex_wd_o, ex_wreg_o, ex_is_load_o, ex_inst_invalid_o
   );

   modport slave (
      input ex_valid_o, ex_pc_o, ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o,
            ex_wd_o, ex_wreg_o, ex_is_load_o, ex_inst_invalid_o
   );

endinterface

// File: rtl/id_fwd_mux.sv
// One read port's operand select (imm / $0 / EX / MEM / regfile) and its hazard compare.
module id_fwd_mux
   import defines_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int FWD_EN     = 1
) (
   input  logic                  read_i,
   input  logic [REG_ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0]     imm_i,
   input  logic [DATA_W-1:0]     rf_data_i,
   input  logic                  ex_wreg_i,
   input  logic [REG_ADDR_W-1:0] ex_wd_i,
   input  logic [DATA_W-1:0]     ex_wdata_i,
   input  logic                  ex_is_load_i,
   input  logic                  mem_wreg_i,
   input  logic [REG_ADDR_W-1:0] mem_wd_i,
   input  logic [DATA_W-1:0]     mem_wdata_i,
   output logic [DATA_W-1:0]     data_o,
   output logic                  hazard_o
);

   logic addrZero;
   logic exHit;
   logic memHit;

   assign addrZero = (addr_i == '0);
   assign exHit    = ex_wreg_i && (ex_wd_i == addr_i) && !addrZero;
   assign memHit   = mem_wreg_i && (mem_wd_i == addr_i) && !addrZero;

   always_comb begin
      data_o = rf_data_i;
      if (!read_i) begin
         data_o = imm_i;
      end else if (addrZero) begin
         data_o = '0;
      end else if ((FWD_EN != 0) && exHit) begin
         data_o = ex_wdata_i;
      end else if ((FWD_EN != 0) && memHit) begin
         data_o = mem_wdata_i;
      end
   end

   // Without forwarding, any in-flight producer of this register must be waited out.
   assign hazard_o = read_i && ((exHit && ex_is_load_i) ||
                                ((FWD_EN == 0) && (exHit || memHit)));

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage (logic/shift/LUI/LW) with forwarding, load-use bubble and ID/EX register.
module id_stage
   import defines_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int ALUOP_W    = 8,
   parameter int ALUSEL_W   = 3,
   parameter int FWD_EN     = 1,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall_i,
   input  logic                  flush_i,
   input  logic                  valid_i,
   input  logic [DATA_W-1:0]     pc_i,
   input  logic [31:0]           inst_i,
   input  logic [DATA_W-1:0]     reg1_data_i,
   input  logic [DATA_W-1:0]     reg2_data_i,
   output logic                  reg1_read_o,
   output logic                  reg2_read_o,
   output logic [REG_ADDR_W-1:0] reg1_addr_o,
   output logic [REG_ADDR_W-1:0] reg2_addr_o,
   input  logic                  ex_wreg_i,
   input  logic [REG_ADDR_W-1:0] ex_wd_i,
   input  logic [DATA_W-1:0]     ex_wdata_i,
   input  logic                  ex_is_load_i,
   input  logic                  mem_wreg_i,
   input  logic [REG_ADDR_W-1:0] mem_wd_i,
   input  logic [DATA_W-1:0]     mem_wdata_i,
   output logic                  stallreq_o,
   id_stage_if.master            ex,
   output logic [CNT_W-1:0]      bubble_cnt_o
);

   typedef struct packed {
      logic                  valid;
      logic [DATA_W-1:0]     pc;
      logic [ALUOP_W-1:0]    aluop;
      logic [ALUSEL_W-1:0]   alusel;
      logic [DATA_W-1:0]     reg1;
      logic [DATA_W-1:0]     reg2;
      logic [REG_ADDR_W-1:0] wd;
      logic                  wreg;
      logic                  isLoad;
      logic                  invalid;
   } payload_t;

   logic [5:0]            op;
   logic [5:0]            funct;
   logic [4:0]            sa;
   logic [15:0]           imm;
   logic [DATA_W-1:0]     imm1;
   logic [DATA_W-1:0]     imm2;
   logic [DATA_W-1:0]     opnd1;
   logic [DATA_W-1:0]     opnd2;
   logic                  haz1;
   logic                  haz2;
   logic [REG_ADDR_W-1:0] wdDec;
   logic                  wregDec;
   logic [ALUOP_W-1:0]    aluopDec;
   logic [ALUSEL_W-1:0]   aluselDec;
   logic                  loadDec;
   logic                  invalidDec;
   payload_t              dec;
   payload_t              payload_d;
   payload_t              payload_q;
   logic [CNT_W-1:0]      cnt_d;
   logic [CNT_W-1:0]      cnt_q;

   assign op          = inst_i[31:26];
   assign funct       = inst_i[5:0];
   assign sa          = inst_i[10:6];
   assign imm         = inst_i[15:0];
   assign reg1_addr_o = REG_ADDR_W'(inst_i[25:21]);
   assign reg2_addr_o = REG_ADDR_W'(inst_i[20:16]);

   // Reserved encodings read nothing and carry zero operands so they can never stall.
   always_comb begin
      reg1_read_o = 1'b0;
      reg2_read_o = 1'b0;
      imm1        = '0;
      imm2        = '0;
      wdDec       = REG_ADDR_W'(NOPRegAddr);
      wregDec     = WriteDisable;
      aluopDec    = ALUOP_W'(EXE_NOP_OP);
      aluselDec   = ALUSEL_W'(EXE_RES_NOP);
      loadDec     = 1'b0;
      invalidDec  = 1'b0;
      if (valid_i) begin
         case (op)
            OP_SPECIAL: begin
               case (funct)
                  FUNCT_AND, FUNCT_OR, FUNCT_XOR, FUNCT_NOR: begin
                     reg1_read_o = 1'b1;
                     reg2_read_o = 1'b1;
                     wdDec       = REG_ADDR_W'(inst_i[15:11]);
                     wregDec     = WriteEnable;
                     aluselDec   = ALUSEL_W'(EXE_RES_LOGIC);
                     case (funct)
                        FUNCT_AND: aluopDec = ALUOP_W'(EXE_AND_OP);
                        FUNCT_OR:  aluopDec = ALUOP_W'(EXE_OR_OP);
                        FUNCT_XOR: aluopDec = ALUOP_W'(EXE_XOR_OP);
                        default:   aluopDec = ALUOP_W'(EXE_NOR_OP);
                     endcase
                  end
                  FUNCT_SLL, FUNCT_SRL, FUNCT_SRA: begin
                     reg2_read_o = 1'b1;
                     imm1        = DATA_W'(sa);
                     wdDec       = REG_ADDR_W'(inst_i[15:11]);
                     wregDec     = WriteEnable;
                     aluselDec   = ALUSEL_W'(EXE_RES_SHIFT);
                     case (funct)
                        FUNCT_SLL: aluopDec = ALUOP_W'(EXE_SLL_OP);
                        FUNCT_SRL: aluopDec = ALUOP_W'(EXE_SRL_OP);
                        default:   aluopDec = ALUOP_W'(EXE_SRA_OP);
                     endcase
                  end
                  default: invalidDec = 1'b1;
               endcase
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
               reg1_read_o = 1'b1;
               imm2        = DATA_W'(imm);
               wdDec       = REG_ADDR_W'(inst_i[20:16]);
               wregDec     = WriteEnable;
               aluselDec   = ALUSEL_W'(EXE_RES_LOGIC);
               case (op)
                  OP_ANDI: aluopDec = ALUOP_W'(EXE_AND_OP);
                  OP_ORI:  aluopDec = ALUOP_W'(EXE_OR_OP);
                  default: aluopDec = ALUOP_W'(EXE_XOR_OP);
               endcase
            end
            OP_LUI: begin
               imm2      = DATA_W'({imm, 16'h0000});
               wdDec     = REG_ADDR_W'(inst_i[20:16]);
               wregDec   = WriteEnable;
               aluopDec  = ALUOP_W'(EXE_OR_OP);
               aluselDec = ALUSEL_W'(EXE_RES_LOGIC);
            end
            OP_LW: begin
               reg1_read_o = 1'b1;
               imm2        = DATA_W'(signed'(imm));
               wdDec       = REG_ADDR_W'(inst_i[20:16]);
               wregDec     = WriteEnable;
               aluopDec    = ALUOP_W'(EXE_LW_OP);
               aluselDec   = ALUSEL_W'(EXE_RES_LOAD_STORE);
               loadDec     = 1'b1;
            end
            default: invalidDec = 1'b1;
         endcase
      end
   end

   id_fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .FWD_EN(FWD_EN)) u_fwd1 (
      .read_i(reg1_read_o), .addr_i(reg1_addr_o), .imm_i(imm1), .rf_data_i(reg1_data_i),
      .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
      .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
      .data_o(opnd1), .hazard_o(haz1)
   );

   id_fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .FWD_EN(FWD_EN)) u_fwd2 (
      .read_i(reg2_read_o), .addr_i(reg2_addr_o), .imm_i(imm2), .rf_data_i(reg2_data_i),
      .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
      .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
      .data_o(opnd2), .hazard_o(haz2)
   );

   assign stallreq_o = !rst && (haz1 || haz2);

   assign dec = '{valid: valid_i, pc: pc_i, aluop: aluopDec, alusel: aluselDec,
                  reg1: opnd1, reg2: opnd2, wd: wdDec, wreg: wregDec,
                  isLoad: loadDec, invalid: invalidDec};

   // A bubble is the all-zero payload because the NOP aluop/alusel encodings are zero.
   always_comb begin
      payload_d = payload_q;
      cnt_d     = cnt_q;
      if (flush_i) begin
         payload_d = '0;
      end else if (!stall_i) begin
         if (stallreq_o) begin
            payload_d = '0;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
         end else begin
            payload_d = dec;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         payload_q <= '0;
         cnt_q     <= '0;
      end else begin
         payload_q <= payload_d;
         cnt_q     <= cnt_d;
      end
   end

   assign ex.ex_valid_o        = payload_q.valid;
   assign ex.ex_pc_o           = payload_q.pc;
   assign ex.ex_aluop_o        = payload_q.aluop;
   assign ex.ex_alusel_o       = payload_q.alusel;
   assign ex.ex_reg1_o         = payload_q.reg1;
   assign ex.ex_reg2_o         = payload_q.reg2;
   assign ex.ex_wd_o           = payload_q.wd;
   assign ex.ex_wreg_o         = payload_q.wreg;
   assign ex.ex_is_load_o      = payload_q.isLoad;
   assign ex.ex_inst_invalid_o = payload_q.invalid;
   assign bubble_cnt_o         = cnt_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed and randomized checks of id_stage against an instruction-level reference model.
module tb_id_stage;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 3;
   localparam int CNT_MAX = (1 << CW) - 1;
   localparam logic [7:0] LOGIC_TAB [4] = '{8'h24, 8'h25, 8'h26, 8'h27};

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [7:0]  aluop;
      logic [2:0]  alusel;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [4:0]  wd;
      logic        wreg;
      logic        isLoad;
      logic        invalid;
   } pay_t;

   logic          clk = 1'b0;
   logic          rst, stall_i, flush_i, valid_i;
   logic [DW-1:0] pc_i, reg1_data_i, reg2_data_i;
   logic [31:0]   inst_i;
   logic          reg1_read_o, reg2_read_o;
   logic [AW-1:0] reg1_addr_o, reg2_addr_o;
   logic          ex_wreg_i, ex_is_load_i, mem_wreg_i;
   logic [AW-1:0] ex_wd_i, mem_wd_i;
   logic [DW-1:0] ex_wdata_i, mem_wdata_i;
   logic          stallreq_o;
   logic [CW-1:0] bubble_cnt_o;

   int   total = 0;
   int   bad = 0;
   pay_t expDec, expQ;
   int   expCnt;
   logic expRd1, expRd2, expStall;

   always #5 clk = ~clk;

   id_stage_if #(.DATA_W(DW), .REG_ADDR_W(AW), .ALUOP_W(8), .ALUSEL_W(3)) exIf ();

   id_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .ALUOP_W(8), .ALUSEL_W(3), .FWD_EN(1), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
      .pc_i(pc_i), .inst_i(inst_i), .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
      .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
      .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
      .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
      .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
      .stallreq_o(stallreq_o), .ex(exIf), .bubble_cnt_o(bubble_cnt_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] srcVal(input logic [4:0] a, input logic [31:0] rf);
      if (a == 5'd0) return 32'h0;
      if (ex_wreg_i && ex_wd_i == a) return ex_wdata_i;
      if (mem_wreg_i && mem_wd_i == a) return mem_wdata_i;
      return rf;
   endfunction

   task automatic modelDecode();
      logic [5:0] op, fn;
      logic [4:0] rs, rt, rd, sa;
      logic [15:0] imm;
      logic logicR, shiftR, logicI, lui, lw, legal;
      op = inst_i[31:26]; fn = inst_i[5:0];
      rs = inst_i[25:21]; rt = inst_i[20:16]; rd = inst_i[15:11]; sa = inst_i[10:6];
      imm = inst_i[15:0];
      logicR = (op == 6'h00) && (fn inside {6'h24, 6'h25, 6'h26, 6'h27});
      shiftR = (op == 6'h00) && (fn inside {6'h00, 6'h02, 6'h03});
      logicI = op inside {6'h0C, 6'h0D, 6'h0E};
      lui = (op == 6'h0F);
      lw = (op == 6'h23);
      legal = valid_i && (logicR || shiftR || logicI || lui || lw);
      expRd1 = legal && (logicR || logicI || lw);
      expRd2 = legal && (logicR || shiftR);
      expDec = '0;
      expDec.valid = valid_i;
      expDec.pc = pc_i;
      expDec.invalid = valid_i && !legal;
      if (legal) begin
         expDec.wreg = 1'b1;
         expDec.wd = (logicR || shiftR) ? rd : rt;
         expDec.isLoad = lw;
         if (logicR)      expDec.aluop = LOGIC_TAB[int'(fn) - 'h24];
         else if (logicI) expDec.aluop = LOGIC_TAB[int'(op) - 'h0C];
         else if (lui)    expDec.aluop = LOGIC_TAB[1];
         else if (shiftR) expDec.aluop = (fn == 6'h00) ? 8'h7C : {2'b00, fn};
         else             expDec.aluop = 8'hE3;
         expDec.alusel = (logicR || logicI || lui) ? 3'd1 : shiftR ? 3'd2 : 3'd7;
         expDec.r1 = expRd1 ? srcVal(rs, reg1_data_i) : shiftR ? {27'h0, sa} : 32'h0;
         expDec.r2 = expRd2 ? srcVal(rt, reg2_data_i) : logicI ? {16'h0, imm} :
                     lui ? {imm, 16'h0} : {{16{imm[15]}}, imm};
      end
      expStall = !rst && ex_is_load_i && ex_wreg_i && (ex_wd_i != 5'd0) &&
                 ((expRd1 && ex_wd_i == rs) || (expRd2 && ex_wd_i == rt));
   endtask

   task automatic modelClock();
      if (rst) begin
         expQ = '0;
         expCnt = 0;
      end else if (flush_i) begin
         expQ = '0;
      end else if (!stall_i) begin
         if (expStall) begin
            expQ = '0;
            if (expCnt < CNT_MAX) expCnt++;
         end else begin
            expQ = expDec;
         end
      end
   endtask

   task automatic checkComb();
      check("stallreq", 32'(stallreq_o), 32'(expStall));
      check("reg1_read", 32'(reg1_read_o), 32'(expRd1));
      check("reg2_read", 32'(reg2_read_o), 32'(expRd2));
      check("reg1_addr", 32'(reg1_addr_o), 32'(inst_i[25:21]));
      check("reg2_addr", 32'(reg2_addr_o), 32'(inst_i[20:16]));
   endtask

   task automatic checkOutput();
      check("ex_valid", 32'(exIf.ex_valid_o), 32'(expQ.valid));
      check("ex_pc", exIf.ex_pc_o, expQ.pc);
      check("ex_aluop", 32'(exIf.ex_aluop_o), 32'(expQ.aluop));
      check("ex_alusel", 32'(exIf.ex_alusel_o), 32'(expQ.alusel));
      check("ex_reg1", exIf.ex_reg1_o, expQ.r1);
      check("ex_reg2", exIf.ex_reg2_o, expQ.r2);
      check("ex_wd", 32'(exIf.ex_wd_o), 32'(expQ.wd));
      check("ex_wreg", 32'(exIf.ex_wreg_o), 32'(expQ.wreg));
      check("ex_is_load", 32'(exIf.ex_is_load_o), 32'(expQ.isLoad));
      check("ex_invalid", 32'(exIf.ex_inst_invalid_o), 32'(expQ.invalid));
      check("bubble_cnt", 32'(bubble_cnt_o), 32'(expCnt));
   endtask

   task automatic runCycle();
      #1;
      modelDecode();
      checkComb();
      @(posedge clk);
      modelClock();
      #1;
      checkOutput();
   endtask

   task automatic applyStimulus(input logic [31:0] inst);
      inst_i = inst;
      valid_i = 1'b1;
      pc_i = pc_i + 32'd4;
      runCycle();
   endtask

   task automatic idleFwd();
      ex_wreg_i = 1'b0; ex_wd_i = '0; ex_wdata_i = '0; ex_is_load_i = 1'b0;
      mem_wreg_i = 1'b0; mem_wd_i = '0; mem_wdata_i = '0;
   endtask

   function automatic logic [31:0] randInst();
      int kind;
      logic [4:0] rs, rt, rd, sa;
      logic [15:0] imm;
      logic [5:0] shTab [3];
      shTab = '{6'h00, 6'h02, 6'h03};
      kind = $urandom_range(0, 13);
      rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 3)); sa = 5'($urandom_range(0, 31));
      imm = 16'($urandom);
      if (kind <= 3) return {6'h00, rs, rt, rd, sa, 6'h24 + 6'(kind)};
      if (kind <= 6) return {6'h00, rs, rt, rd, sa, shTab[kind - 4]};
      if (kind <= 9) return {6'h0C + 6'(kind - 7), rs, rt, imm};
      if (kind == 10) return {6'h0F, sa, rt, imm};
      if (kind <= 12) return {6'h23, rs, rt, imm};
      if ($urandom_range(0, 1) == 1) return {6'h3F, 26'($urandom)};
      return {6'h00, rs, rt, rd, sa, 6'h20};
   endfunction

   initial begin
      rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
      pc_i = '0; inst_i = '0; reg1_data_i = '0; reg2_data_i = '0;
      expQ = '0; expCnt = 0;
      idleFwd();
      runCycle();
      check("reset_wreg", 32'(exIf.ex_wreg_o), 32'h0);
      rst = 1'b0;

      // ORI $2,$1,0x00F0 from the regfile
      reg1_data_i = 32'h0000_1200;
      applyStimulus({6'h0D, 5'd1, 5'd2, 16'h00F0});
      check("ori_reg1", exIf.ex_reg1_o, 32'h0000_1200);
      check("ori_reg2", exIf.ex_reg2_o, 32'h0000_00F0);
      check("ori_wd", 32'(exIf.ex_wd_o), 32'd2);
      check("ori_aluop", 32'(exIf.ex_aluop_o), 32'h25);

      // OR $3,$1,$2: EX beats MEM, then $0 reads zero
      ex_wreg_i = 1'b1; ex_wd_i = 5'd1; ex_wdata_i = 32'hAAAA_0000;
      mem_wreg_i = 1'b1; mem_wd_i = 5'd1; mem_wdata_i = 32'h1;
      applyStimulus({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h25});
      check("or_ex_prio", exIf.ex_reg1_o, 32'hAAAA_0000);
      ex_wd_i = 5'd0;
      applyStimulus({6'h00, 5'd0, 5'd2, 5'd3, 5'd0, 6'h25});
      check("or_zero_reg", exIf.ex_reg1_o, 32'h0);

      // LW $4 then AND $5,$4,$6: one bubble then MEM forwarding
      idleFwd();
      applyStimulus({6'h23, 5'd1, 5'd4, 16'h0008});
      ex_wreg_i = 1'b1; ex_wd_i = 5'd4; ex_is_load_i = 1'b1; ex_wdata_i = 32'hDEAD_BEEF;
      applyStimulus({6'h00, 5'd4, 5'd6, 5'd5, 5'd0, 6'h24});
      check("lu_bubble_wreg", 32'(exIf.ex_wreg_o), 32'h0);
      check("lu_cnt", 32'(bubble_cnt_o), 32'd1);
      idleFwd();
      mem_wreg_i = 1'b1; mem_wd_i = 5'd4; mem_wdata_i = 32'h0000_0055;
      pc_i = pc_i - 32'd4;
      applyStimulus({6'h00, 5'd4, 5'd6, 5'd5, 5'd0, 6'h24});
      check("lu_mem_fwd", exIf.ex_reg1_o, 32'h0000_0055);
      idleFwd();

      applyStimulus({6'h0F, 5'd0, 5'd7, 16'h1234});
      check("lui_reg2", exIf.ex_reg2_o, 32'h1234_0000);
      applyStimulus({6'h00, 5'd0, 5'd9, 5'd8, 5'd4, 6'h03});
      check("sra_reg1", exIf.ex_reg1_o, 32'd4);
      applyStimulus(32'hFC00_0000);
      check("invalid_flag", 32'(exIf.ex_inst_invalid_o), 32'h1);

      // flush wins over stall; stall holds even with a pending load-use
      flush_i = 1'b1; stall_i = 1'b1;
      applyStimulus({6'h0D, 5'd1, 5'd2, 16'h0001});
      check("flush_valid", 32'(exIf.ex_valid_o), 32'h0);
      flush_i = 1'b0; stall_i = 1'b0;
      applyStimulus({6'h0E, 5'd1, 5'd3, 16'h00FF});
      stall_i = 1'b1;
      ex_wreg_i = 1'b1; ex_wd_i = 5'd1; ex_is_load_i = 1'b1;
      applyStimulus({6'h0C, 5'd1, 5'd2, 16'h0F0F});
      applyStimulus({6'h00, 5'd1, 5'd1, 5'd2, 5'd0, 6'h26});

      // drive the counter into saturation, then reset mid-stall
      stall_i = 1'b0;
      for (int i = 0; i < CNT_MAX + 2; i++) begin
         pc_i = pc_i - 32'd4;
         applyStimulus({6'h00, 5'd1, 5'd6, 5'd5, 5'd0, 6'h24});
      end
      check("cnt_saturated", 32'(bubble_cnt_o), 32'(CNT_MAX));
      stall_i = 1'b1; rst = 1'b1;
      applyStimulus({6'h00, 5'd1, 5'd6, 5'd5, 5'd0, 6'h24});
      check("rst_cnt", 32'(bubble_cnt_o), 32'h0);
      rst = 1'b0; stall_i = 1'b0;
      idleFwd();

      for (int i = 0; i < 800; i++) begin
         rst = ($urandom_range(0, 63) == 0);
         flush_i = ($urandom_range(0, 15) == 0);
         stall_i = ($urandom_range(0, 7) == 0);
         valid_i = ($urandom_range(0, 7) != 0);
         inst_i = randInst();
         pc_i = $urandom;
         reg1_data_i = $urandom;
         reg2_data_i = $urandom;
         ex_wreg_i = ($urandom_range(0, 1) == 1);
         ex_wd_i = 5'($urandom_range(0, 3));
         ex_wdata_i = $urandom;
         ex_is_load_i = ($urandom_range(0, 2) == 0);
         mem_wreg_i = ($urandom_range(0, 1) == 1);
         mem_wd_i = 5'($urandom_range(0, 3));
         mem_wdata_i = $urandom;
         runCycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/id_stage.md
# id_stage

Parametrised MIPS decode stage with an integrated ID/EX pipeline register. It decodes the logic, shift, LUI and LW subset and forwards operands from EX and MEM. It detects load-use hazards, inserting a bubble and requesting a stall, and supports hold and flush from the pipeline controller. It sits between the IF/ID register and the EX stage, reads the regfile combinationally, and presents registered operands to EX one cycle later.

## Interface
Parameters:
- DATA_W, 32, operand/PC width
- REG_ADDR_W, 5, register address width
- ALUOP_W, 8, aluop field width
- ALUSEL_W, 3, alusel field width
- FWD_EN, 1, 1 = EX/MEM forwarding on; 0 = regfile data only, with hazard stall on any EX/MEM match
- CNT_W, 16, bubble counter width

Ports (clock `clk`, reset `rst`: one clock, synchronous, active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall_i  in  1  controller hold of ID/EX register
- flush_i  in  1  controller flush, inserts a bubble
- valid_i  in  1  inst_i is a real instruction
- pc_i  in  DATA_W  instruction address
- inst_i  in  32  instruction word
- reg1_data_i / reg2_data_i  in  DATA_W  regfile read data
- reg1_read_o / reg2_read_o  out  1  regfile read enables (combinational)
- reg1_addr_o / reg2_addr_o  out  REG_ADDR_W  inst[25:21] / inst[20:16] (combinational)
- ex_wreg_i, ex_wd_i, ex_wdata_i, ex_is_load_i  in  1/REG_ADDR_W/DATA_W/1  EX-stage result
- mem_wreg_i, mem_wd_i, mem_wdata_i  in  1/REG_ADDR_W/DATA_W  MEM-stage result
- stallreq_o  out  1  load-use stall request (combinational)
- ex_valid_o, ex_pc_o, ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o, ex_is_load_o  out  registered EX payload
- ex_inst_invalid_o  out  1  registered reserved-instruction flag
- bubble_cnt_o  out  CNT_W  saturating count of load-use bubbles

## Operation
- Decode (op = inst[31:26]):
  - SPECIAL, funct 0x24/25/26/27 (AND/OR/XOR/NOR): read rs and rt, write rd.
  - SPECIAL, funct 0x00/02/03 (SLL/SRL/SRA): read rt only. reg1 = zero-extended sa (inst[10:6]), reg2 = rt. Write rd.
  - ANDI 0x0C, ORI 0x0D, XORI 0x0E: reg1 = rs, reg2 = {16'h0, imm16}, write rt.
  - LUI 0x0F: reg1 = 0, reg2 = {imm16, 16'h0}, write rt.
  - LW 0x23: reg1 = rs, reg2 = sign-extended imm16, write rt, is_load = 1.
  - Any other op/funct: invalid = 1, wreg = 0, NOP aluop/alusel.
- valid_i = 0: treated as NOP. No reads, no hazard, no invalid flag.
- Operand source per read port, in priority order:
  1. Register 0 reads 0.
  2. EX match (ex_wreg_i && ex_wd_i == addr) gives ex_wdata_i.
  3. MEM match gives mem_wdata_i.
  4. Otherwise, regfile data.
  - A port that is not read uses the immediate or sa per the decode table above.
- Hazard: stallreq_o = 1 when valid_i, ex_is_load_i, ex_wreg_i, ex_wd_i ≠ 0, and ex_wd_i equals an address that is actually read. If FWD_EN = 0, any nonzero EX or MEM match also raises stallreq_o.
- ID/EX register update, in priority order:
  1. rst: all outputs 0.
  2. flush_i: bubble.
  3. stall_i: hold.
  4. stallreq_o: bubble, and bubble_cnt_o increments, saturating at all-ones.
  5. Otherwise: load decoded payload; ex_valid_o = valid_i.
- Bubble: ex_valid_o = 0, ex_wreg_o = 0, ex_is_load_o = 0, ex_inst_invalid_o = 0, ex_aluop_o/ex_alusel_o = NOP, all other fields 0.
- The upstream controller must hold IF/ID while stallreq_o = 1. This block does not latch inst_i.

## Timing
- Decode, forwarding and stallreq_o are combinational in the same cycle as inst_i.
- Payload appears on ex_* one clk edge later (latency 1).
- Load-use: exactly one bubble per LW→dependent pair. On the next cycle the load is in MEM and the value comes from the MEM path.
- flush_i and stall_i in the same cycle: flush wins.
- stall_i together with stallreq_o: hold, and the counter does not increment.
- Reset mid-stream clears the register and the counter on the next edge. stallreq_o is 0 while rst = 1.

## Structure
- Shared package `defines_pkg`:
  - Opcode and funct constants.
  - EXE_*_OP aluop and EXE_RES_* alusel encodings.
  - NOP register address.
  - Write enable/disable constants.
  - ZeroWord.
- One natural sub-module, `id_fwd_mux`: the per-port forwarding mux plus hazard compare. It is instantiated twice, once per read port.

## Test plan
- ORI $2,$1,0x00F0 with regfile $1 = 0x0000_1200, no forwarding → next cycle ex_reg1 = 0x1200, ex_reg2 = 0x00F0, ex_wd = 2, ex_wreg = 1, ex_aluop = OR.
- OR $3,$1,$2 with EX writing $1 = 0xAAAA_0000 and MEM writing $1 = 0x1 → ex_reg1 = 0xAAAA_0000, confirming EX priority. Repeat with ex_wd = 0 → no forwarding, $0 reads 0.
- LW $4 followed by AND $5,$4,$6 → stallreq_o = 1 for one cycle, bubble with ex_wreg = 0, bubble_cnt_o = 1. Next cycle the MEM path supplies $4 and the AND issues.
- LUI $7,0x1234 → ex_reg2 = 0x1234_0000. SRA $8,$9,4 → ex_reg1 = 4, reg1_read_o = 0.
- Opcode 0x3F → ex_inst_invalid_o = 1, ex_wreg = 0. flush_i asserted at the same time as stall_i → bubble. rst mid-stall → all outputs and the counter become 0.
- Force bubble_cnt_o to all-ones, then trigger another load-use stall → value stays all-ones.
